// File: rtl/wb_stage_buf.sv
// wb_stage_buf: write-back stage with a DEPTH-entry write FIFO toward the register file.
// Retiring instructions are accepted over a valid/ready handshake and formatted at enqueue.
// Each formatted result is buffered and issued to a stallable RF write port.
// A SYSCALL drains all older writes and then parks the stage in a sticky halted state.
// Optional feature: define WB_FWD_EN to add the fwd_valid/fwd_num/fwd_data forwarding outputs.
module wb_stage_buf #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_inst,
    input  logic [XLEN-1:0]             in_pc,
    input  logic [XLEN-1:0]             in_alu_result,
    input  logic [XLEN-1:0]             in_mem_data,
    input  logic [$clog2(XLEN/8)-1:0]   in_mem_offset,
    input  logic [1:0]                  in_mem_size,
    input  logic                        in_mem_unsigned,
    input  logic                        in_mem_to_reg,
    input  logic                        in_reg_dst,
    input  logic [1:0]                  in_jump,
    input  logic                        in_reg_write,
    input  logic                        rf_stall,
    output logic                        rf_we,
    output logic [4:0]                  rf_wnum,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        halted,
    output logic [CNT_W-1:0]            retired_count
`ifdef WB_FWD_EN
    ,
    output logic                        fwd_valid,
    output logic [4:0]                  fwd_num,
    output logic [XLEN-1:0]             fwd_data
`endif
);

    localparam int OFF_W = $clog2(XLEN/8);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Big-endian lane select: lane k is the most significant byte after shifting left by k bytes,
    // so every access size takes its bytes from the top of the shifted word.
    function automatic logic [XLEN-1:0] fmt_load(
        input logic [XLEN-1:0]  data,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             uns
    );
        logic [1:0]             size_eff;
        logic [OFF_W-1:0]       mask;
        logic [OFF_W-1:0]       off_al;
        logic [XLEN-1:0]        sh;
        logic signed [XLEN-1:0] sh_s;
        int unsigned            drop;
        // A dword request on a 32-bit datapath degrades to a word access.
        size_eff = ((XLEN == 32) && (size == 2'b11)) ? 2'b10 : size;
        // Misaligned offsets are silently aligned down to the access size.
        mask     = OFF_W'((1 << size_eff) - 1);
        off_al   = off & ~mask;
        sh       = data << {off_al, 3'b000};
        sh_s     = $signed(sh);
        drop     = XLEN - (8 << size_eff);
        if (uns) begin
            fmt_load = sh >> drop;
        end else begin
            fmt_load = sh_s >>> drop;
        end
    endfunction

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   we_mem_q   [DEPTH];
    logic [4:0]             num_mem_q  [DEPTH];
    logic [XLEN-1:0]        data_mem_q [DEPTH];
    logic                   halt_mem_q [DEPTH];

    logic                   rf_we_q, rf_we_d;
    logic [4:0]             rf_wnum_q, rf_wnum_d;
    logic [XLEN-1:0]        rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]       retired_q, retired_d;

    logic [4:0]             enq_num;
    logic [XLEN-1:0]        enq_data;
    logic                   enq_we;
    logic                   enq_halt;
    logic                   push;
    logic                   pop;
    logic                   head_we;
    logic [4:0]             head_num;
    logic [XLEN-1:0]        head_data;
    logic                   head_halt;
    logic                   unused_inst_bits;

    // Register fields not consulted by the write-back stage.
    assign unused_inst_bits = ^{in_inst[25:21], in_inst[10:6]};

    // Enqueue formatting: destination index, result data, write enable and halt marker.
    always_comb begin
        enq_num  = in_inst[20:16];
        enq_data = in_alu_result;
        if (in_reg_dst) begin
            enq_num = in_inst[15:11];
        end else if (in_jump == 2'b10) begin
            enq_num = 5'd31;
        end
        if (in_mem_to_reg) begin
            enq_data = fmt_load(in_mem_data, in_mem_offset, in_mem_size, in_mem_unsigned);
        end else if (in_jump == 2'b10) begin
            enq_data = in_pc + XLEN'(LINK_OFFSET);
        end
        enq_halt = (in_inst[31:26] == 6'd0) && (in_inst[5:0] == 6'h0C);
        // The halt marker never writes; writes to $0 are dropped but still retire.
        enq_we   = in_reg_write && (enq_num != 5'd0) && !enq_halt;
    end

    assign in_ready  = (state_q == ST_RUN) && (count_q < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (count_q != '0) && !rf_stall;
    assign head_we   = we_mem_q[rd_ptr_q];
    assign head_num  = num_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign head_halt = halt_mem_q[rd_ptr_q];

    // FIFO pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage holds data only; reset empties the FIFO through the pointers instead.
    always_ff @(posedge clk) begin
        if (push) begin
            we_mem_q[wr_ptr_q]   <= enq_we;
            num_mem_q[wr_ptr_q]  <= enq_num;
            data_mem_q[wr_ptr_q] <= enq_data;
            halt_mem_q[wr_ptr_q] <= enq_halt;
        end
    end

    // RF port and retire counter next state: load from the head only on a pop edge.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_wnum_d  = rf_wnum_q;
        rf_wdata_d = rf_wdata_q;
        retired_d  = retired_q;
        if (pop) begin
            rf_we_d    = head_we;
            rf_wnum_d  = head_num;
            rf_wdata_d = head_data;
            if (!head_halt) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic: SYSCALL acceptance starts the drain, the halt marker popping ends it.
    always_comb begin
        state_d = state_q;
        halted  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (push && enq_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_wnum_q  <= '0;
            rf_wdata_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_wnum_q  <= rf_wnum_d;
            rf_wdata_q <= rf_wdata_d;
            retired_q  <= retired_d;
        end
    end

    assign rf_we         = rf_we_q;
    assign rf_wnum       = rf_wnum_q;
    assign rf_wdata      = rf_wdata_q;
    assign retired_count = retired_q;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Forwarding: youngest valid FIFO write wins, walking oldest to youngest; else the RF register.
    always_comb begin
        fwd_valid = rf_we_q;
        fwd_num   = rf_wnum_q;
        fwd_data  = rf_wdata_q;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if ((CW'(i) < count_q) && we_mem_q[fwd_idx]) begin
                fwd_valid = 1'b1;
                fwd_num   = num_mem_q[fwd_idx];
                fwd_data  = data_mem_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Self-checking bench for wb_stage_buf (XLEN=32, DEPTH=4, default build).
module tb_wb_stage_buf;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic        we;
        logic [4:0]  num;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [1:0]  in_mem_offset;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic        in_mem_to_reg;
    logic        in_reg_dst;
    logic [1:0]  in_jump;
    logic        in_reg_write;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_wnum;
    logic [31:0] rf_wdata;
    logic        halted;
    logic [31:0] retired_count;

    int total = 0;
    int bad   = 0;

    wb_stage_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .LINK_OFFSET(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_mem_offset(in_mem_offset),
        .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_dst(in_reg_dst), .in_jump(in_jump),
        .in_reg_write(in_reg_write), .rf_stall(rf_stall), .rf_we(rf_we),
        .rf_wnum(rf_wnum), .rf_wdata(rf_wdata), .halted(halted),
        .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Load value assembled byte by byte from big-endian lanes, then extended.
    function automatic logic [31:0] ref_load(input logic [31:0] d, input int off, input int size,
                                             input bit uns);
        int     n;
        int     k;
        longint v;
        n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        k = off - (off % n);
        v = 0;
        for (int i = 0; i < n; i++) begin
            v = (v << 8) | ((longint'(d) >> (8 * (3 - (k + i)))) & 255);
        end
        if (!uns && v >= (longint'(1) << (8 * n - 1))) begin
            v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    // Expected FIFO entry for the instruction currently on the inputs.
    function automatic exp_t model_entry();
        exp_t e;
        if (in_reg_dst)            e.num = in_inst[15:11];
        else if (in_jump == 2'b10) e.num = 5'd31;
        else                       e.num = in_inst[20:16];
        if (in_mem_to_reg)
            e.data = ref_load(in_mem_data, int'(in_mem_offset), int'(in_mem_size), in_mem_unsigned);
        else if (in_jump == 2'b10)
            e.data = in_pc + 32'd8;
        else
            e.data = in_alu_result;
        e.we = in_reg_write && (e.num != 5'd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] md, input logic [1:0] off, input logic [1:0] size,
                          input logic uns, input logic m2r, input logic rdst,
                          input logic [1:0] jump, input logic rw);
        in_inst = inst; in_pc = pc; in_alu_result = alu; in_mem_data = md;
        in_mem_offset = off; in_mem_size = size; in_mem_unsigned = uns;
        in_mem_to_reg = m2r; in_reg_dst = rdst; in_jump = jump; in_reg_write = rw;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rf_stall = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        rf_stall = 1'b0;
        rst = 1'b1;
        #2;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
        total++; if (rf_wnum !== 5'd0) begin bad++; $display("FAIL reset_wnum got=%0d want=0", rf_wnum); end
        total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired_count); end
        rst = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_byte_load();
        apply_reset();
        set_in({6'h20, 5'd0, 5'd5, 16'h0}, 32'h0, 32'h0, 32'h12F45678, 2'd1, 2'b00,
               1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL byte_latency got=%b want=0", rf_we); end
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL byte_we got=%b want=1", rf_we); end
        total++; if (rf_wnum !== 5'd5) begin bad++; $display("FAIL byte_wnum got=%0d want=5", rf_wnum); end
        total++; if (rf_wdata !== 32'hFFFFFFF4) begin bad++; $display("FAIL byte_wdata got=%h want=fffffff4", rf_wdata); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL byte_we_drop got=%b want=0", rf_we); end
    endtask

    task automatic test_half_load();
        apply_reset();
        set_in({6'h25, 5'd0, 5'd9, 16'h0}, 32'h0, 32'h0, 32'h8001ABCD, 2'd3, 2'b01,
               1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total++; if (rf_wdata !== 32'h0000ABCD) begin bad++; $display("FAIL half_wdata got=%h want=0000abcd", rf_wdata); end
        total++; if (rf_wnum !== 5'd9) begin bad++; $display("FAIL half_wnum got=%0d want=9", rf_wnum); end
    endtask

    task automatic test_jal();
        apply_reset();
        set_in({6'h03, 26'h0}, 32'h100, 32'hDEAD, 32'h0, 2'd0, 2'b10,
               1'b0, 1'b0, 1'b0, 2'b10, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL jal_we got=%b want=1", rf_we); end
        total++; if (rf_wnum !== 5'd31) begin bad++; $display("FAIL jal_wnum got=%0d want=31", rf_wnum); end
        total++; if (rf_wdata !== 32'h108) begin bad++; $display("FAIL jal_wdata got=%h want=108", rf_wdata); end
    endtask

    task automatic test_zero_write();
        apply_reset();
        set_in({6'h08, 5'd1, 5'd0, 16'h0}, 32'h0, 32'h55, 32'h0, 2'd0, 2'b10,
               1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL zero_we got=%b want=0", rf_we); end
        total++; if (retired_count !== 32'd1) begin bad++; $display("FAIL zero_retired got=%0d want=1", retired_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rf_stall = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_in({6'h0, 5'd0, 5'd0, 5'(i + 1), 11'h020}, 32'h0, 32'h10 + i, 32'h0, 2'd0,
                   2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
            in_valid = 1'b1;
            total++;
            if (in_ready !== (i < DEPTH)) begin
                bad++; $display("FAIL bp_ready_%0d got=%b want=%b", i, in_ready, (i < DEPTH));
            end
            step();
        end
        in_valid = 1'b0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bp_stalled_we got=%b want=0", rf_we); end
        rf_stall = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            step();
            total++;
            if (rf_we !== 1'b1 || rf_wnum !== 5'(j + 1) || rf_wdata !== 32'h10 + j) begin
                bad++;
                $display("FAIL bp_drain_%0d got=%b/%0d/%h want=1/%0d/%h", j, rf_we, rf_wnum,
                         rf_wdata, j + 1, 32'h10 + j);
            end
        end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bp_empty_we got=%b want=0", rf_we); end
        total++; if (retired_count !== 32'd4) begin bad++; $display("FAIL bp_retired got=%0d want=4", retired_count); end
    endtask

    task automatic test_halt();
        logic [31:0] seen[$];
        int          idx;
        bit          sys_acc;
        bit          acc;
        apply_reset();
        idx = 0;
        sys_acc = 1'b0;
        for (int c = 0; c < 40; c++) begin
            rf_stall = c[0];
            if (idx < 5) begin
                if (idx == 3)
                    set_in(32'h0000000C, 32'h0, 32'h0, 32'h0, 2'd0, 2'b10,
                           1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
                else
                    set_in({16'h0, 5'(10 + idx), 11'h020}, 32'h0, 32'hA0 + idx, 32'h0,
                           2'd0, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (sys_acc && in_ready !== 1'b0) begin
                total++; bad++;
                $display("FAIL halt_ready_after_sys cycle=%0d got=%b want=0", c, in_ready);
            end
            acc = in_valid && in_ready;
            step();
            if (rf_we === 1'b1) seen.push_back(rf_wdata);
            if (acc) begin
                if (idx == 3) sys_acc = 1'b1;
                idx++;
            end
        end
        in_valid = 1'b0;
        rf_stall = 1'b0;
        total++; if (idx !== 4) begin bad++; $display("FAIL halt_accepts got=%0d want=4", idx); end
        total++; if (seen.size() !== 3) begin bad++; $display("FAIL halt_writes got=%0d want=3", seen.size()); end
        for (int i = 0; i < seen.size() && i < 3; i++) begin
            total++;
            if (seen[i] !== 32'hA0 + i) begin
                bad++; $display("FAIL halt_order_%0d got=%h want=%h", i, seen[i], 32'hA0 + i);
            end
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL halt_ready got=%b want=0", in_ready); end
        total++; if (retired_count !== 32'd3) begin bad++; $display("FAIL halt_retired got=%0d want=3", retired_count); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        set_in({16'h0, 5'd7, 11'h020}, 32'h0, 32'h77, 32'h0, 2'd0, 2'b10,
               1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        total++; if (rf_wnum !== 5'd7) begin bad++; $display("FAIL mid_pre_wnum got=%0d want=7", rf_wnum); end
        rf_stall = 1'b1;
        set_in({16'h0, 5'd8, 11'h020}, 32'h0, 32'h88, 32'h0, 2'd0, 2'b10,
               1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
        in_valid = 1'b1;
        step();
        set_in(32'h0000000C, 32'h0, 32'h0, 32'h0, 2'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_drain_ready got=%b want=0", in_ready); end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        rf_stall = 1'b0;
        step();
        total++;
        if (rf_we !== 1'b0 || rf_wnum !== 5'd0 || rf_wdata !== 32'h0 || halted !== 1'b0 ||
            retired_count !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset_outs got=%b/%0d/%h/%b/%0d want=0/0/0/0/0", rf_we, rf_wnum,
                     rf_wdata, halted, retired_count);
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b want=1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_discard_%0d got=%b want=0", c, rf_we); end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t h;
        int   ret_exp;
        bit   mrdy;
        bit   mpop;
        bit   exp_we;
        apply_reset();
        ret_exp = 0;
        h = '{we: 1'b0, num: 5'd0, data: 32'h0};
        for (int c = 0; c < 420; c++) begin
            set_in($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (in_inst[31:26] == 6'd0 && in_inst[5:0] == 6'h0C) in_inst[0] = 1'b1;
            if (c < 400) begin
                in_valid = ($urandom_range(0, 9) < 7);
                rf_stall = ($urandom_range(0, 9) < 3);
            end else begin
                in_valid = 1'b0;
                rf_stall = 1'b0;
            end
            mrdy = (q.size() < DEPTH);
            mpop = (q.size() != 0) && !rf_stall;
            e = model_entry();
            total++;
            if (in_ready !== mrdy) begin
                bad++; $display("FAIL rnd_ready cycle=%0d got=%b want=%b", c, in_ready, mrdy);
            end
            step();
            if (mpop) begin
                h = q.pop_front();
                ret_exp++;
            end
            if (in_valid && mrdy) q.push_back(e);
            exp_we = mpop && h.we;
            total++;
            if (rf_we !== exp_we) begin
                bad++; $display("FAIL rnd_we cycle=%0d got=%b want=%b", c, rf_we, exp_we);
            end else if (exp_we) begin
                total++;
                if (rf_wnum !== h.num || rf_wdata !== h.data) begin
                    bad++;
                    $display("FAIL rnd_write cycle=%0d got=%0d/%h want=%0d/%h", c, rf_wnum,
                             rf_wdata, h.num, h.data);
                end
            end
        end
        total++;
        if (retired_count !== 32'(ret_exp)) begin
            bad++; $display("FAIL rnd_retired got=%0d want=%0d", retired_count, ret_exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        rf_stall = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        test_reset();
        test_byte_load();
        test_half_load();
        test_jal();
        test_zero_write();
        test_backpressure();
        test_halt();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
